// File: rtl/bp_pkg.sv
// Shared definitions for the gshare + BTB branch predictor.
// Fetch-side lookup and commit-side update both compute their table indices
// with these helpers, so the two paths always agree on where an entry lives.
package bp_pkg;

    localparam int DEF_IDX_W     = 9;
    localparam int DEF_CTR_W     = 2;
    localparam int DEF_HIST_W    = 8;
    localparam int DEF_BTB_IDX_W = 6;
    localparam int DEF_TAG_W     = 8;

    // Weakly-not-taken counter value for the default counter width
    localparam logic [DEF_CTR_W-1:0] CTR_RESET = 2'b01;

    // Mask with the low w bits set (saturates at a full 32-bit mask)
    function automatic logic [31:0] low_mask(input int w);
        if (w >= 32) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

    // Weakly-not-taken value for an arbitrary counter width: 2^(w-1)-1
    function automatic logic [31:0] ctr_reset_value(input int ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    // PHT index: word-address bits XORed with the (zero-extended) history
    function automatic logic [31:0] pht_index(input logic [31:0] a,
                                              input logic [31:0] h,
                                              input int          idx_w);
        return ((a >> 2) ^ h) & low_mask(idx_w);
    endfunction

    // BTB set index: word-address bits directly above the byte offset
    function automatic logic [31:0] btb_index(input logic [31:0] a,
                                              input int          btb_idx_w);
        return (a >> 2) & low_mask(btb_idx_w);
    endfunction

    // BTB tag: the address bits immediately above the set index
    function automatic logic [31:0] btb_tag(input logic [31:0] a,
                                            input int          btb_idx_w,
                                            input int          tag_w);
        return (a >> (btb_idx_w + 2)) & low_mask(tag_w);
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped, tagged branch target buffer.
// Lookup is purely combinational; one write port overwrites whatever entry
// currently occupies the set. Only the valid bits need a reset, since a
// clear valid bit hides any stale tag/target contents.
module bp_btb
    import bp_pkg::*;
#(
    parameter int BTB_IDX_W = DEF_BTB_IDX_W,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_addr,
    output logic        rd_hit,
    output logic [31:0] rd_target,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_target
);

    localparam int ENTRIES = 1 << BTB_IDX_W;

    logic                 valid   [ENTRIES];
    logic [TAG_W-1:0]     tags    [ENTRIES];
    logic [31:0]          targets [ENTRIES];

    logic [BTB_IDX_W-1:0] rd_idx;
    logic [BTB_IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic [TAG_W-1:0]     wr_tag;

    assign rd_idx = BTB_IDX_W'(btb_index(rd_addr, BTB_IDX_W));
    assign rd_tag = TAG_W'(btb_tag(rd_addr, BTB_IDX_W, TAG_W));
    assign wr_idx = BTB_IDX_W'(btb_index(wr_addr, BTB_IDX_W));
    assign wr_tag = TAG_W'(btb_tag(wr_addr, BTB_IDX_W, TAG_W));

    assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_target = targets[rd_idx];

    // Valid bits: cleared asynchronously, set by any write to the set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload, written alongside the valid bit
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/gshare_btb_predictor.sv
// gshare direction predictor with a tagged BTB for targets.
// Prediction is combinational from the fetch PC and the current global
// history; the PHT, BTB and history are trained from the commit path, and
// the history is repaired from the branch's own snapshot on a mispredict.
// Expected parameter range: CTR_W >= 2, 1 <= HIST_W <= IDX_W.
module gshare_btb_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W     = DEF_IDX_W,
    parameter int CTR_W     = DEF_CTR_W,
    parameter int HIST_W    = DEF_HIST_W,
    parameter int BTB_IDX_W = DEF_BTB_IDX_W,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [31:0]       addr,
    input  logic              spec_en,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic              pred_hit,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_en,
    input  logic [31:0]       upd_addr,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_mispredict
);

    localparam int               PHT_ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT    = CTR_W'(ctr_reset_value(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};

    logic [HIST_W-1:0] ghr;
    logic [HIST_W-1:0] ghr_next;
    logic [CTR_W-1:0]  pht [PHT_ENTRIES];

    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic              pred_dir;
    logic [CTR_W-1:0]  upd_ctr;
    logic [CTR_W-1:0]  upd_ctr_next;
    logic              btb_we;

    // Fetch side: index with the live history, commit side: with the snapshot
    assign pred_idx = IDX_W'(pht_index(addr, 32'(ghr), IDX_W));
    assign upd_idx  = IDX_W'(pht_index(upd_addr, 32'(upd_hist), IDX_W));

    assign pred_dir   = pht[pred_idx][CTR_W-1];
    assign pred_taken = pred_dir && pred_hit;
    assign pred_hist  = ghr;

    // Only taken branches allocate or refresh a BTB entry
    assign btb_we = rdy && upd_en && upd_taken;

    bp_btb #(
        .BTB_IDX_W (BTB_IDX_W),
        .TAG_W     (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (addr),
        .rd_hit    (pred_hit),
        .rd_target (pred_target),
        .wr_en     (btb_we),
        .wr_addr   (upd_addr),
        .wr_target (upd_target)
    );

    // Saturating increment/decrement of the counter being trained
    always_comb begin
        upd_ctr      = pht[upd_idx];
        upd_ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != CTR_MAX) begin
                upd_ctr_next = upd_ctr + CTR_W'(1);
            end
        end else if (upd_ctr != '0) begin
            upd_ctr_next = upd_ctr - CTR_W'(1);
        end
    end

    // Pattern history table: reset to weakly-not-taken, trained at commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (rdy && upd_en) begin
            pht[upd_idx] <= upd_ctr_next;
        end
    end

    // Next history: repair from the snapshot beats the speculative shift
    always_comb begin
        ghr_next = ghr;
        if (rdy && upd_en && upd_mispredict) begin
            ghr_next = HIST_W'({upd_hist, upd_taken});
        end else if (rdy && spec_en) begin
            ghr_next = HIST_W'({ghr, pred_taken});
        end
    end

    // Global history register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

endmodule
